// File: rtl/memristor_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : memristor_pulse_gen
// Description : Multi-channel programmable pulse-train generator for memristor
//               programming (high/low timing, pulse count, continuous mode).
// Revision    : 1.0 - initial release
// ============================================================================
module memristor_pulse_gen #(
    parameter int NCH = 3,
    parameter int CW  = 8,
    parameter int TW  = 4
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [NCH-1:0] ch_en_i,
    input  logic [CW-1:0]  num_pulses_i,
    input  logic [TW-1:0]  high_cycles_i,
    input  logic [TW-1:0]  low_cycles_i,
    input  logic           continuous_i,
    output logic [NCH-1:0] pulse_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [CW-1:0]  pulse_cnt_o
);

    typedef enum logic [1:0] {
        c_idle = 2'd0,
        c_high = 2'd1,
        c_low  = 2'd2,
        c_done = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [NCH-1:0] r_cfg_en;
    logic [CW-1:0]  r_cfg_num;
    logic [TW-1:0]  r_cfg_high;
    logic [TW-1:0]  r_cfg_low;
    logic           r_cfg_cont;
    logic [TW-1:0]  r_dur;
    logic [TW-1:0]  w_dur_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_latch;
    logic [NCH-1:0] w_en_nxt;
    logic [NCH-1:0] r_pulse;
    logic [NCH-1:0] w_pulse_nxt;
    logic           r_busy;
    logic           r_done;

    // Remaining-cycles value loaded on state entry; zero-length fields act as one cycle.
    function automatic logic [TW-1:0] dur_load(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_dur_nxt   = r_dur;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            c_idle: begin
                if (start_i && !abort_i) begin
                    w_latch   = 1'b1;
                    w_cnt_nxt = '0;
                    if (num_pulses_i == '0) begin
                        w_state_nxt = c_done;
                    end else begin
                        w_state_nxt = c_high;
                        w_dur_nxt   = dur_load(high_cycles_i);
                    end
                end
            end
            c_high: begin
                if (abort_i) begin
                    w_state_nxt = c_idle;
                end else if (r_dur == '0) begin
                    w_state_nxt = c_low;
                    w_dur_nxt   = dur_load(r_cfg_low);
                    w_cnt_nxt   = r_cnt + CW'(1);
                end else begin
                    w_dur_nxt = r_dur - TW'(1);
                end
            end
            c_low: begin
                if (abort_i) begin
                    w_state_nxt = c_idle;
                end else if (r_dur == '0) begin
                    if (r_cnt < r_cfg_num) begin
                        w_state_nxt = c_high;
                        w_dur_nxt   = dur_load(r_cfg_high);
                    end else if (r_cfg_cont) begin
                        w_state_nxt = c_high;
                        w_dur_nxt   = dur_load(r_cfg_high);
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = c_done;
                    end
                end else begin
                    w_dur_nxt = r_dur - TW'(1);
                end
            end
            c_done: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // Outputs are computed from the next state so they register without extra latency.
    assign w_en_nxt    = w_latch ? ch_en_i : r_cfg_en;
    assign w_pulse_nxt = (w_state_nxt == c_high) ? w_en_nxt : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state    <= c_idle;
            r_cfg_en   <= '0;
            r_cfg_num  <= '0;
            r_cfg_high <= '0;
            r_cfg_low  <= '0;
            r_cfg_cont <= 1'b0;
            r_dur      <= '0;
            r_cnt      <= '0;
            r_pulse    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dur   <= w_dur_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= (w_state_nxt != c_idle);
            r_done  <= (w_state_nxt == c_done);
            if (w_latch) begin
                r_cfg_en   <= ch_en_i;
                r_cfg_num  <= num_pulses_i;
                r_cfg_high <= high_cycles_i;
                r_cfg_low  <= low_cycles_i;
                r_cfg_cont <= continuous_i;
            end
        end
    end

    assign pulse_o     = r_pulse;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pulse_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: doc/memristor_pulse_gen.md
MEMRISTOR_PULSE_GEN -- requirements
Module: memristor_pulse_gen

Interface
REQ-001 Parameter NCH, default 3: number of memristor pulse channels.
REQ-002 Parameter CW, default 8: width of the pulse-count fields.
REQ-003 Parameter TW, default 4: width of the high-time and low-time fields.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-005 wb_clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-006 wb_rst_i  input  1  asynchronous, active-low reset.
REQ-007 start_i  input  1  single-cycle request to begin a pulse train.
REQ-008 abort_i  input  1  stop the train immediately.
REQ-009 ch_en_i  input  NCH  per-channel enable, latched on start.
REQ-010 num_pulses_i  input  CW  pulses per train, latched on start.
REQ-011 high_cycles_i  input  TW  pulse-high duration in clocks, latched on start.
REQ-012 low_cycles_i  input  TW  inter-pulse gap in clocks, latched on start.
REQ-013 continuous_i  input  1  repeat the train until aborted, latched on start.
REQ-014 pulse_o  output  NCH  registered pulse outputs.
REQ-015 busy_o  output  1  high while not in IDLE.
REQ-016 done_o  output  1  one-cycle completion strobe.
REQ-017 pulse_cnt_o  output  CW  pulses completed in the current train.

Function
REQ-018 The FSM SHALL have four states: IDLE, HIGH, LOW, DONE; busy_o = (state != IDLE).
REQ-019 In IDLE, start_i=1 with abort_i=0 SHALL latch all configuration inputs, clear pulse_cnt_o and move to:
- DONE if num_pulses_i=0;
- HIGH otherwise.
REQ-020 Configuration inputs SHALL be ignored outside the IDLE start cycle; start_i SHALL be ignored while busy.
REQ-021 Timing: pulse_o SHALL first go high in the cycle after the start_i sample edge (one-clock latency).
REQ-022 HIGH behaviour:
- pulse_o = latched ch_en;
- lasts max(high,1) cycles;
- on exit, pulse_cnt_o increments by 1 (modulo 2^CW).
REQ-023 LOW behaviour:
- pulse_o = 0;
- lasts max(low,1) cycles.
REQ-024 Exit from LOW:
- if pulse_cnt_o < latched num_pulses, go to HIGH;
- else, if continuous, clear pulse_cnt_o and go to HIGH;
- else, go to DONE.
REQ-025 DONE SHALL last one cycle with done_o=1 and pulse_o=0, then go to IDLE.
REQ-026 abort_i=1 in HIGH, LOW or DONE SHALL:
- force IDLE at the next edge;
- clear pulse_o;
- leave pulse_cnt_o unchanged;
- not assert done_o.
REQ-027 If start_i and abort_i are both high in IDLE, abort SHALL win and the block stays in IDLE.
REQ-028 Latched ch_en=0 SHALL still run full state timing and counting, with pulse_o held at 0.
REQ-029 Duration counters SHALL be TW bits wide; the maximum field value (2^TW-1) SHALL produce exactly that many cycles, with no wrap.
REQ-030 pulse_o, busy_o and done_o SHALL be glitch-free register outputs.

Reset
REQ-031 wb_rst_i=0 SHALL asynchronously force:
- state = IDLE;
- pulse_o = 0, busy_o = 0, done_o = 0, pulse_cnt_o = 0;
- all latched configuration = 0.
REQ-032 Reset asserted mid-train SHALL drop pulse_o within the same cycle, with no done_o.
REQ-033 After reset deasserts, the first start_i SHALL be honoured on the first rising edge.

Verification
REQ-034 start, num=3, high=2, low=1, ch_en=3'b101 -> pulse_o = 101,101,000 repeated 3 times; done_o in cycle 10; pulse_cnt_o=3.
REQ-035 start, num=0 -> no pulse; done_o one cycle after start; busy_o high for exactly 1 cycle.
REQ-036 start, num=2, continuous=1, high=1, low=1 -> pulses every 2 cycles; pulse_cnt_o cycles 1,2,1,2...; abort -> IDLE next edge, pulse_o=0, no done_o.
REQ-037 high=0, low=0, num=2 -> behaves as high=1, low=1: 2 one-cycle pulses, 1 cycle apart.
REQ-038 wb_rst_i low during HIGH -> pulse_o=0 immediately; all outputs 0; a subsequent start runs normally.
REQ-039 start with abort in the same IDLE cycle -> stays IDLE; start while busy -> train unaffected; high=15 -> exactly 15-cycle pulse.
